// File: rtl/mux4_to_1.sv
// Four-way data selector with a combinational output and an enable-qualified
// registered copy that also tracks capture validity and select changes.
`timescale 1ns/1ps

module mux4_to_1 #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s0,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [1:0]       sel_q,
    output logic             q_vld,
    output logic             sel_chg
);

    localparam logic [WIDTH-1:0] RST_VAL_W = WIDTH'(RST_VAL);

    logic [1:0]       sel_s;
    logic [WIDTH-1:0] out_q_d;
    logic [1:0]       sel_q_d;
    logic             q_vld_d;
    logic             sel_chg_d;

    assign sel_s = {s1, s0};

    // Combinational select; an unknown select propagates X instead of picking an input
    always_comb begin
        out = {WIDTH{1'bx}};
        case (sel_s)
            2'b00:   out = a;
            2'b01:   out = b;
            2'b10:   out = c;
            2'b11:   out = d;
            default: out = {WIDTH{1'bx}};
        endcase
    end

    // Next-state for the capture registers; sel_chg only pulses on a capture edge
    always_comb begin
        out_q_d   = out_q;
        sel_q_d   = sel_q;
        q_vld_d   = q_vld;
        sel_chg_d = 1'b0;
        if (en) begin
            out_q_d   = out;
            sel_q_d   = sel_s;
            q_vld_d   = 1'b1;
            sel_chg_d = q_vld && (sel_s != sel_q);
        end else begin
            sel_chg_d = 1'b0;
        end
    end

    // Capture registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= RST_VAL_W;
            sel_q   <= 2'b00;
            q_vld   <= 1'b0;
            sel_chg <= 1'b0;
        end else begin
            out_q   <= out_q_d;
            sel_q   <= sel_q_d;
            q_vld   <= q_vld_d;
            sel_chg <= sel_chg_d;
        end
    end

endmodule

// File: tb/tb_mux4_to_1.sv
// Randomised scoreboard bench for mux4_to_1: a reference model queues the
// expected register state per clock edge and a monitor checks it on negedge.
`timescale 1ns/1ps

module tb_mux4_to_1;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
    logic         s1 = 1'b0, s0 = 1'b0, en = 1'b0;
    logic [W-1:0] out, out_q;
    logic [1:0]   sel_q;
    logic         q_vld, sel_chg;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    typedef struct {
        logic [W-1:0] oq;
        logic [1:0]   sq;
        logic         v;
        logic         chg;
    } exp_t;

    exp_t sb[$];

    // model state: what was last captured and how many captures since reset
    logic [W-1:0] m_data = '0;
    int           m_sel  = 0;
    int           m_caps = 0;

    mux4_to_1 #(.WIDTH(W), .RST_VAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .s1(s1), .s0(s0), .en(en), .out(out), .out_q(out_q),
        .sel_q(sel_q), .q_vld(q_vld), .sel_chg(sel_chg)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input int sel);
        logic [W-1:0] srcs [4];
        srcs[0] = a; srcs[1] = b; srcs[2] = c; srcs[3] = d;
        return srcs[sel];
    endfunction

    function automatic int cur_sel();
        return int'(s1) * 2 + int'(s0);
    endfunction

    // reference model: one expected register image per clock edge
    always @(posedge clk) begin
        exp_t e;
        bit   changed;
        changed = 1'b0;
        if (!rst_n) begin
            m_data = '0; m_sel = 0; m_caps = 0;
        end else if (en) begin
            changed = (m_caps > 0) && (cur_sel() != m_sel);
            m_data  = pick(cur_sel());
            m_sel   = cur_sel();
            m_caps++;
        end
        e.oq  = m_data;
        e.sq  = 2'(m_sel);
        e.v   = (m_caps > 0);
        e.chg = changed;
        sb.push_back(e);
    end

    // asynchronous reset wipes model and pending expectations
    always @(negedge rst_n) begin
        sb.delete();
        m_data = '0; m_sel = 0; m_caps = 0;
    end

    // monitor: compare registered outputs half a cycle after each edge
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            pops++;
            chk("sb_out_q",   32'(out_q),   32'(e.oq));
            chk("sb_sel_q",   32'(sel_q),   32'(e.sq));
            chk("sb_q_vld",   32'(q_vld),   32'(e.v));
            chk("sb_sel_chg", 32'(sel_chg), 32'(e.chg));
        end
    end

    task automatic drive(input logic [W-1:0] ia, ib, ic, id, input int sel, input logic ien);
        a = ia; b = ib; c = ic; d = id;
        s1 = sel[1]; s0 = sel[0]; en = ien;
    endtask

    task automatic comb_chk(input string name);
        chk(name, 32'(out), 32'(pick(cur_sel())));
    endtask

    task automatic rst_chk();
        chk("rst_out_q",   32'(out_q),   32'h0);
        chk("rst_sel_q",   32'(sel_q),   32'h0);
        chk("rst_q_vld",   32'(q_vld),   32'h0);
        chk("rst_sel_chg", 32'(sel_chg), 32'h0);
    endtask

    task automatic rnd_cycle(input int en_pct);
        @(posedge clk);
        #2;
        drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
              int'($urandom_range(0, 3)), ($urandom_range(0, 99) < en_pct));
        #1;
        comb_chk("rnd_comb");
    endtask

    initial begin
        // reset state, then exhaustive select/data combinations while held in reset
        #1;
        rst_chk();
        for (int i = 0; i < 64; i++) begin
            drive({W{i[5]}}, {W{i[4]}}, {W{i[3]}}, {W{i[2]}}, i & 3, 1'b0);
            #1;
            comb_chk("exh_comb");
        end
        drive(4'h0, 4'h1, 4'h0, 4'h0, 1, 1'b0);
        #1;
        chk("exh_example", 32'(out), 32'h1);
        @(posedge clk);
        #5 rst_n = 1'b1;

        // select toggling at 4 ns / offset 2 ns with data refreshed after each edge
        @(posedge clk);
        for (int t = 0; t < 200; t++) begin
            s1 = ((t / 4) % 2) != 0;
            s0 = (((t + 2) / 4) % 2) != 0;
            if ((t % 20) == 3) begin
                a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
            end
            #0.5;
            comb_chk("tog_comb");
            #0.5;
        end

        // fresh reset, then first capture of c via select 10, then a switch to 11
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1 rst_chk();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2 drive(4'h0, 4'h0, 4'h1, 4'h0, 2, 1'b1);
        @(posedge clk);
        #2 drive(4'h0, 4'h0, 4'h1, 4'h3, 3, 1'b1);
        #1;
        chk("cap_out_q",   32'(out_q),   32'h1);
        chk("cap_sel_q",   32'(sel_q),   32'h2);
        chk("cap_q_vld",   32'(q_vld),   32'h1);
        chk("cap_sel_chg", 32'(sel_chg), 32'h0);
        @(posedge clk);
        #2 drive(4'h0, 4'h0, 4'h1, 4'h3, 3, 1'b0);
        #1;
        chk("chg_sel_chg", 32'(sel_chg), 32'h1);
        chk("chg_out_q",   32'(out_q),   32'h3);
        @(posedge clk);
        #3;
        chk("chg_pulse_end", 32'(sel_chg), 32'h0);

        // hold: five edges with en low and changing inputs
        for (int i = 0; i < 5; i++) rnd_cycle(0);
        @(posedge clk);
        #3;
        chk("hold_out_q", 32'(out_q), 32'h3);
        chk("hold_sel_q", 32'(sel_q), 32'h3);

        // randomised traffic with occasional mid-cycle resets while enabled
        for (int i = 0; i < 300; i++) begin
            rnd_cycle(75);
            if ($urandom_range(0, 24) == 0) begin
                en = 1'b1;
                #2 rst_n = 1'b0;
                #1 rst_chk();
                comb_chk("rst_comb");
                #5 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #3;
        chk("sb_activity", 32'(pops > 300), 32'h1);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
